nfca_rx_miller_decode: RTL and testbench

NFCA_RX_MILLER_DECODE -- requirements
Module: nfca_rx_miller_decode

---
 rtl/nfca_rx_miller_decode_if.sv | 25 ++
 rtl/nfca_rx_miller_decode.sv | 199 +++++++++++++++++++
 tb/tb_nfca_rx_miller_decode.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/nfca_rx_miller_decode_if.sv
// Purpose: bundles the raw pause input and decoded frame events of the NFC-A Miller decoder.
// Latency: none, wires only.
// Backpressure: none; the decoded events are single-clk pulses and the consumer must sample every clk.
// Ports: rf_pause (envelope detector, 1 = carrier absent) and rx_sof/rx_valid/rx_bit/rx_eof/rx_err/rx_busy.
// The master modport is the decoder. The slave modport is the side that supplies rf_pause
// and consumes the decoded events.
interface nfca_rx_miller_decode_if;
  logic rf_pause;
  logic rx_sof;
  logic rx_valid;
  logic rx_bit;
  logic rx_eof;
  logic rx_err;
  logic rx_busy;

  modport master (
    input  rf_pause,
    output rx_sof, rx_valid, rx_bit, rx_eof, rx_err, rx_busy
  );

  modport slave (
    output rf_pause,
    input  rx_sof, rx_valid, rx_bit, rx_eof, rx_err, rx_busy
  );
endinterface

// File: rtl/nfca_rx_miller_decode.sv
// Purpose: decodes the ISO14443-A reader-to-card modified-Miller pause stream into SOF, data bits and EOF.
// Latency: event pulses appear one clk after slot offset 576. The 2-flop synchronizer adds 2 clks,
//          plus 8 clks when the glitch filter is enabled.
// Backpressure: none; every output is a registered single-clk pulse, except rx_busy, which is a level.
// Ports: clk, rst (async, active high), bus (master modport: rf_pause in, rx_* out).
// Build option: define NFCA_RX_GLITCH_FILTER_EN to ignore pauses shorter than 8 clks.
module nfca_rx_miller_decode #(
  parameter int TOL       = 48,
  parameter int MAX_PAUSE = 320
) (
  input  logic                           clk,
  input  logic                           rst,
  nfca_rx_miller_decode_if.master        bus
);

  typedef enum logic {IDLE, RX} state_t;

  localparam logic [9:0] SLOT_LAST = 10'd767;
  localparam logic [9:0] SLOT_MID  = 10'd384;
  localparam logic [9:0] CLASS_AT  = 10'd576;
  localparam logic [9:0] Z_LO      = 10'(768 - TOL);
  localparam logic [9:0] Z_HI      = 10'(TOL);
  localparam logic [9:0] X_LO      = 10'(384 - TOL);
  localparam logic [9:0] X_HI      = 10'(384 + TOL);
  localparam logic [8:0] PLEN_LAST = 9'(MAX_PAUSE - 1);

  logic [1:0] sync_q;
  logic       p;
  logic       p_d;
  logic       pause_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], bus.rf_pause};
  end

`ifdef NFCA_RX_GLITCH_FILTER_EN
  // p only follows the synchronized input after it has disagreed with p for 8 clks in a row.
  logic [2:0] filt_cnt;
  logic       p_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= 3'd0;
      p_filt   <= 1'b0;
    end else if (sync_q[1] != p_filt) begin
      if (filt_cnt == 3'd7) begin
        p_filt   <= sync_q[1];
        filt_cnt <= 3'd0;
      end else begin
        filt_cnt <= filt_cnt + 3'd1;
      end
    end else begin
      filt_cnt <= 3'd0;
    end
  end

  assign p = p_filt;
`else
  assign p = sync_q[1];
`endif

  // p_d tracks p on every clk. After an abort during a long pause, a new SOF therefore
  // needs p to return to 0 and then rise again.
  assign pause_edge = p & ~p_d;

  state_t     state;
  logic [9:0] cnt;
  logic [8:0] pause_len;
  logic       flag_z;
  logic       flag_x;
  logic       prev;
  logic       sof_slot;
  logic       sof_r, valid_r, bit_r, eof_r, err_r, busy_r;

  logic win_z, win_x, plen_hit;
  assign win_z    = (cnt >= Z_LO) || (cnt <= Z_HI);
  assign win_x    = (cnt >= X_LO) && (cnt <= X_HI);
  assign plen_hit = p && (pause_len == PLEN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 10'd0;
      pause_len <= 9'd0;
      flag_z    <= 1'b0;
      flag_x    <= 1'b0;
      prev      <= 1'b0;
      sof_slot  <= 1'b0;
      p_d       <= 1'b0;
      sof_r     <= 1'b0;
      valid_r   <= 1'b0;
      bit_r     <= 1'b0;
      eof_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      p_d     <= p;
      sof_r   <= 1'b0;
      valid_r <= 1'b0;
      eof_r   <= 1'b0;
      err_r   <= 1'b0;

      case (state)
        IDLE: begin
          cnt       <= 10'd0;
          pause_len <= 9'd0;
          flag_z    <= 1'b0;
          flag_x    <= 1'b0;
          prev      <= 1'b0;
          sof_slot  <= 1'b0;
          if (pause_edge) begin
            state    <= RX;
            busy_r   <= 1'b1;
            flag_z   <= 1'b1;
            sof_slot <= 1'b1;
          end
        end

        RX: begin
          // Free-running slot timer. Pause edges below re-align it to the reader's grid.
          if (cnt == SLOT_LAST) begin
            cnt    <= 10'd0;
            flag_z <= 1'b0;
            flag_x <= 1'b0;
          end else begin
            cnt <= cnt + 10'd1;
          end

          if (p) pause_len <= pause_len + 9'd1;
          else   pause_len <= 9'd0;

          if (plen_hit) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            err_r  <= 1'b1;
          end else if (pause_edge) begin
            if (win_z) begin
              // An edge just before the wrap starts the next slot early, so the old X flag is dropped.
              cnt    <= 10'd0;
              flag_z <= 1'b1;
              if (cnt >= Z_LO) flag_x <= 1'b0;
            end else if (win_x) begin
              cnt    <= SLOT_MID;
              flag_x <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
              err_r  <= 1'b1;
            end
          end else if (cnt == CLASS_AT) begin
            if (flag_z && flag_x) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              err_r  <= 1'b1;
            end else if (sof_slot) begin
              sof_r    <= 1'b1;
              sof_slot <= 1'b0;
            end else if (flag_x) begin
              valid_r <= 1'b1;
              bit_r   <= 1'b1;
              prev    <= 1'b1;
            end else if (flag_z) begin
              if (prev) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                err_r  <= 1'b1;
              end else begin
                valid_r <= 1'b1;
                bit_r   <= 1'b0;
              end
            end else if (prev) begin
              valid_r <= 1'b1;
              bit_r   <= 1'b0;
              prev    <= 1'b0;
            end else begin
              eof_r  <= 1'b1;
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_sof   = sof_r;
  assign bus.rx_valid = valid_r;
  assign bus.rx_bit   = bit_r;
  assign bus.rx_eof   = eof_r;
  assign bus.rx_err   = err_r;
  assign bus.rx_busy  = busy_r;

endmodule

// File: tb/tb_nfca_rx_miller_decode.sv
// Purpose: directed self-checking bench for nfca_rx_miller_decode.
// Latency: events are compared per frame, after the frame's last slot has elapsed.
// Backpressure: not applicable.
// Event codes: 1 = sof, 2 = bit 0, 3 = bit 1, 4 = eof, 5 = err.
module tb_nfca_rx_miller_decode;

  logic clk = 1'b0;
  logic rst;
  always #6 clk = ~clk;

  nfca_rx_miller_decode_if bus();

  nfca_rx_miller_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int start;
    int len;
  } pause_t;

  pause_t pq[$];
  int     ev_q[$];
  int     exp_q[$];
  int     cyc;
  int     t0;
  int     slot_k;
  int     n_tests;
  int     n_fail;
  int     multi;
  bit     prev_tb;
  bit     jit_en;
  int     jit_tab [8] = '{0, 20, 40, 20, 0, -20, -40, -20};
  logic [63:0] data64;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return {26'd0, bus.rx_sof, bus.rx_valid, bus.rx_bit, bus.rx_eof, bus.rx_err, bus.rx_busy};
  endfunction

  // Cycle counter that defines the timing grid of the pause schedule.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Drive rf_pause from the queue of scheduled pauses. Entries must be queued in time order.
  initial begin
    bus.rf_pause = 1'b0;
    forever begin
      @(negedge clk);
      while (pq.size() != 0 && cyc >= pq[0].start + pq[0].len) void'(pq.pop_front());
      bus.rf_pause = (pq.size() != 0 && cyc >= pq[0].start);
    end
  end

  // Record every decoded event, and count clks in which more than one event pulse is high.
  initial begin
    forever begin
      @(negedge clk);
      if (int'(bus.rx_sof) + int'(bus.rx_valid) + int'(bus.rx_eof) + int'(bus.rx_err) > 1) multi++;
      if (bus.rx_sof)   ev_q.push_back(1);
      if (bus.rx_valid) ev_q.push_back(bus.rx_bit ? 3 : 2);
      if (bus.rx_eof)   ev_q.push_back(4);
      if (bus.rx_err)   ev_q.push_back(5);
    end
  end

  task automatic pause_at(input int off, input int len);
    pause_t e;
    e.start = t0 + off;
    e.len   = len;
    pq.push_back(e);
  endtask

  task automatic run_until(input int off);
    while (cyc < t0 + off) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_frame();
    t0 = cyc + 8;
    ev_q.delete();
    exp_q.delete();
    slot_k  = 1;
    prev_tb = 1'b0;
  endtask

  task automatic begin_frame();
    start_frame();
    pause_at(0, 192);
    exp_q.push_back(1);
  endtask

  // Modified Miller: 1 -> X (pause at mid-slot); 0 after 0 -> Z (pause at slot start);
  // 0 after 1 -> Y (no pause).
  task automatic send_bit(input bit b);
    int j;
    j = jit_en ? jit_tab[slot_k % 8] : 0;
    if (b)             pause_at(slot_k * 768 + 384 + j, 192);
    else if (!prev_tb) pause_at(slot_k * 768 + j, 192);
    exp_q.push_back(b ? 3 : 2);
    prev_tb = b;
    slot_k++;
  endtask

  // The end sequence is a logic 0 followed by an empty Y slot. The decoder reports the
  // logic 0 as a data bit, then reports EOF.
  task automatic end_frame();
    send_bit(1'b0);
    slot_k++;
    exp_q.push_back(4);
  endtask

  task automatic check_frame(input string tag);
    check({tag, ".n"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("%s.ev%0d", tag, i), ev_q[i], exp_q[i]);
  endtask

  initial begin
    #(12 * 150000);
    $display("FAIL watchdog: reached cycle %0d, limit 150000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    multi   = 0;
    jit_en  = 1'b0;
    t0      = 0;
    slot_k  = 0;
    prev_tb = 1'b0;
    data64  = 64'hA5C3_0F96_1E2D_B478;
    rst     = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 0);
    rst = 1'b0;

    // Slots Z,X,Y,Z,X,Y,Y: sof, then 1,0,0,1, then 0 (Y after 1), then eof.
    begin_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    end_frame();
    run_until(300);
    check("basic.busy_mid", int'(bus.rx_busy), 1);
    run_until(slot_k * 768);
    check_frame("basic");
    check("basic.busy_end", int'(bus.rx_busy), 0);

    // Pause at offset 200 after SOF falls outside both windows.
    begin_frame();
    exp_q.delete();
    exp_q.push_back(5);
    pause_at(200, 192);
    run_until(3 * 768);
    check_frame("viol200");
    check("viol200.busy", int'(bus.rx_busy), 0);

    // SOF, X, Z: a Z slot directly after a 1 is a coding violation.
    begin_frame();
    send_bit(1'b1);
    pause_at(2 * 768, 192);
    exp_q.push_back(5);
    run_until(4 * 768);
    check_frame("z_after_1");
    check("z_after_1.busy", int'(bus.rx_busy), 0);

    // 64-bit frame with every pause jittered along a +/-40 clk triangle.
    jit_en = 1'b1;
    begin_frame();
    for (int i = 0; i < 64; i++) send_bit(data64[i]);
    end_frame();
    jit_en = 1'b0;
    run_until(slot_k * 768);
    check_frame("jitter64");
    check("jitter64.busy", int'(bus.rx_busy), 0);

    // SOF pause held for 400 clks aborts the frame. A clean frame afterwards still decodes.
    start_frame();
    pause_at(0, 400);
    exp_q.push_back(5);
    run_until(768);
    check_frame("long_pause");
    check("long_pause.busy", int'(bus.rx_busy), 0);
    begin_frame();
    send_bit(1'b1);
    end_frame();
    run_until(slot_k * 768);
    check_frame("after_abort");

    // 4-clk glitch at offset 200: the filtered build ignores it, the default build aborts.
    begin_frame();
    pause_at(200, 4);
`ifdef NFCA_RX_GLITCH_FILTER_EN
    exp_q.push_back(4);
`else
    exp_q.delete();
    exp_q.push_back(5);
`endif
    run_until(3 * 768);
    check_frame("glitch");

    // Reset mid-frame clears every output and produces neither eof nor err.
    begin_frame();
    run_until(768 + 200);
    check("rst_mid.busy_before", int'(bus.rx_busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid.outs", outs(), 0);
    rst = 1'b0;
    run_until(3 * 768);
    check_frame("rst_mid");

    check("one_pulse_per_clk", multi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
